mem_axi_bridge: RTL and testbench
=================================

Name: mem_axi_bridge

Overview:
- Downstream neighbour of the memory-access stage. Converts that stage's single-outstanding bus request into AXI4-Lite master transactions toward the MMU/interconnect.
- Returns exactly one single-cycle response pulse per accepted request, with read data and an error flag.
- Byte lanes and wstrb pass verbatim; endian placement is already resolved upstream.

Parameters:
- PROT_READ, 3'b000, value driven on m_axi_arprot.
- PROT_WRITE, 3'b000, value driven on m_axi_awprot.

Ports:
- clk  input  1  clock
- rstn  input  1  synchronous active-low reset
- request_enable  input  1  one-cycle request strobe from memory stage
- mode  input  1  MEMREQ_READ(0) / MEMREQ_WRITE(1)
- addr  input  32  word-aligned request address
- wdata  input  32  write data, lanes as supplied
- wstrb  input  4  write byte strobes
- response_enable  output  1  one-cycle completion pulse
- data  output  32  read data, valid with response_enable
- resp_error  output  1  high with response_enable if the AXI resp was not OKAY
- busy  output  1  transaction in flight (state != IDLE)
- req_overrun  output  1  sticky: request_enable seen while busy
- m_axi_araddr  output  32;  m_axi_arprot  output  3;  m_axi_arvalid  output  1;  m_axi_arready  input  1
- m_axi_rdata  input  32;  m_axi_rresp  input  2;  m_axi_rvalid  input  1;  m_axi_rready  output  1
- m_axi_awaddr  output  32;  m_axi_awprot  output  3;  m_axi_awvalid  output  1;  m_axi_awready  input  1
- m_axi_wdata  output  32;  m_axi_wstrb  output  4;  m_axi_wvalid  output  1;  m_axi_wready  input  1
- m_axi_bresp  input  2;  m_axi_bvalid  input  1;  m_axi_bready  output  1

Behaviour:
- Reset (rstn low at a clk edge):
  - All valid/ready outputs, response_enable, resp_error, req_overrun and busy go to 0.
  - data and all address, data and strobe outputs go to 0. State goes to IDLE.
  - Reset mid-transaction abandons the transaction immediately; no response pulse is produced.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE:
  - request_enable with mode=READ latches addr into araddr, sets arvalid=1 and moves to RD_ADDR.
  - request_enable with mode=WRITE latches addr, wdata and wstrb into aw/w, sets awvalid=wvalid=1 and moves to WR_REQ.
- RD_ADDR: on arvalid&arready, clear arvalid, set rready=1, move to RD_DATA.
- RD_DATA: on rvalid&rready:
  - Clear rready; data<=rdata; resp_error<=(rresp!=2'b00).
  - response_enable<=1 for one cycle; return to IDLE.
- WR_REQ:
  - awvalid and wvalid each drop independently on their own handshake. The two handshakes may complete on the same edge or on different edges.
  - When both are done, set bready=1 and move to WR_RESP.
  - An address/data value must not change while its valid is high.
- WR_RESP: on bvalid&bready:
  - Clear bready; resp_error<=(bresp!=2'b00); data<=0.
  - Pulse response_enable; return to IDLE.
- Latency with a zero-wait slave (ready and response valid combinationally high): response_enable is high in the 3rd cycle after the edge that sampled request_enable, for both reads and writes.
- AXI stability rules:
  - Valid stays asserted until its handshake; no valid output depends combinationally on any ready input.
  - rvalid or bvalid arriving before the corresponding ready is held by the slave per protocol; no special handling.
- request_enable while busy (including the response cycle):
  - Ignored; req_overrun<=1, sticky until reset.
  - A request in the IDLE cycle immediately after the response is accepted normally.
- response_enable is exactly one cycle; resp_error is 0 whenever response_enable is 0.

Decomposition:
- Shared def package: MEMREQ_READ/MEMREQ_WRITE constants (existing), an AXI resp encoding constant (AXI_RESP_OKAY=2'b00), and a bridge state enum typedef.
- No sub-module; single FSM module.

Test Plan:
- Read, zero-wait slave:
  - Stimulus: request mode=0, addr=0x80001000, slave rdata=0xDEADBEEF, rresp=0.
  - Required: araddr=0x80001000, one AR handshake; response_enable 3 cycles later with data=0xDEADBEEF, resp_error=0.
- Write with W before AW:
  - Stimulus: addr=0x100, wdata=0x00AB0000, wstrb=4'b0100; wready at cycle 1, awready at cycle 4.
  - Required: wvalid drops after cycle 1, awvalid held until cycle 4, bready only after both handshakes; single response_enable after bvalid.
- Error response:
  - Stimulus: read with rresp=2'b10, then write with bresp=2'b11.
  - Required: both responses have resp_error=1; the next OKAY read has resp_error=0.
- Back-pressure:
  - Stimulus: arready low for 5 cycles; araddr changed on the input side meanwhile.
  - Required: m_axi_araddr and arvalid stable for all 5 cycles; exactly one response.
- Overrun:
  - Stimulus: second request_enable while in RD_DATA.
  - Required: no second AR issued; req_overrun=1 until reset; a request one cycle after the response is served normally.
- Reset mid-write:
  - Stimulus: rstn low during WR_REQ with awvalid=1.
  - Required: next cycle all valids=0, busy=0, no response_enable; subsequent read completes normally.

Source files
------------

// File: rtl/mem_axi_bridge_pkg.sv
// Shared definitions for the memory-stage to AXI4-Lite bridge.
//   MEMREQ_READ / MEMREQ_WRITE : request mode encoding from the memory stage
//   AXI_RESP_OKAY              : AXI response code treated as success
//   bridge_state_t             : bridge FSM state encoding
package mem_axi_bridge_pkg;

    localparam logic       MEMREQ_READ   = 1'b0;
    localparam logic       MEMREQ_WRITE  = 1'b1;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } bridge_state_t;

endpackage

// File: rtl/mem_axi_bridge.sv
// Bridge from the memory stage's single-outstanding request to one AXI4-Lite
// master transaction, returning one response_enable pulse per accepted request.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for request_enable
// ST_RD_ADDR | arvalid held until the AR handshake
// ST_RD_DATA | rready held until the R handshake
// ST_WR_REQ  | awvalid / wvalid each held until their own handshake
// ST_WR_RESP | bready held until the B handshake
//
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   request_enable/mode/addr/wdata/wstrb   request from the memory stage
//   response_enable/data/resp_error        one-cycle completion
//   busy                           state != ST_IDLE
//   req_overrun                    sticky: request seen while not able to accept
//   m_axi_*                        AXI4-Lite master channels (AR, R, AW, W, B)
module mem_axi_bridge
    import mem_axi_bridge_pkg::*;
#(
    parameter logic [2:0] PROT_READ  = 3'b000,
    parameter logic [2:0] PROT_WRITE = 3'b000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        request_enable,
    input  logic        mode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        response_enable,
    output logic [31:0] data,
    output logic        resp_error,
    output logic        busy,
    output logic        req_overrun,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    bridge_state_t state_q, state_d;
    logic [31:0]   araddr_q, araddr_d, awaddr_q, awaddr_d;
    logic [31:0]   wdata_q, wdata_d, data_q, data_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          arvalid_q, arvalid_d, rready_q, rready_d;
    logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic          resp_en_q, resp_en_d, resp_err_q, resp_err_d;
    logic          overrun_q, overrun_d;
    logic          accept, aw_done, w_done;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            araddr_q   <= '0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            data_q     <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            resp_en_q  <= 1'b0;
            resp_err_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            araddr_q   <= araddr_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            data_q     <= data_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            resp_en_q  <= resp_en_d;
            resp_err_q <= resp_err_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        araddr_d   = araddr_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        data_d     = data_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        resp_en_d  = 1'b0;
        resp_err_d = 1'b0;
        overrun_d  = overrun_q;
        // The response cycle is already in IDLE but still counts as busy
        // towards the memory stage, so a request there is refused.
        accept     = request_enable && (state_q == ST_IDLE) && !resp_en_q;
        // A channel is done when its valid is already low or handshakes now.
        aw_done    = !awvalid_q || m_axi_awready;
        w_done     = !wvalid_q  || m_axi_wready;

        if (request_enable && !accept) overrun_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (mode == MEMREQ_READ) begin
                        araddr_d  = addr;
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end else begin
                        awaddr_d  = addr;
                        wdata_d   = wdata;
                        wstrb_d   = wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_REQ;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (rready_q && m_axi_rvalid) begin
                    rready_d   = 1'b0;
                    data_d     = m_axi_rdata;
                    resp_err_d = (m_axi_rresp != AXI_RESP_OKAY);
                    resp_en_d  = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (bready_q && m_axi_bvalid) begin
                    bready_d   = 1'b0;
                    data_d     = '0;
                    resp_err_d = (m_axi_bresp != AXI_RESP_OKAY);
                    resp_en_d  = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign response_enable = resp_en_q;
    assign data            = data_q;
    assign resp_error      = resp_err_q;
    assign busy            = (state_q != ST_IDLE);
    assign req_overrun     = overrun_q;
    assign m_axi_araddr    = araddr_q;
    assign m_axi_arprot    = PROT_READ;
    assign m_axi_arvalid   = arvalid_q;
    assign m_axi_rready    = rready_q;
    assign m_axi_awaddr    = awaddr_q;
    assign m_axi_awprot    = PROT_WRITE;
    assign m_axi_awvalid   = awvalid_q;
    assign m_axi_wdata     = wdata_q;
    assign m_axi_wstrb     = wstrb_q;
    assign m_axi_wvalid    = wvalid_q;
    assign m_axi_bready    = bready_q;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Testbench for mem_axi_bridge: directed scenarios plus randomized
// transactions against a transaction-level expectation (one response per
// request, data/error from the slave, latency from the slave delays).
module tb_mem_axi_bridge;
    import mem_axi_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        request_enable, mode;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        response_enable, resp_error, busy, req_overrun;
    logic [31:0] data;
    logic [31:0] m_axi_araddr, m_axi_rdata, m_axi_awaddr, m_axi_wdata;
    logic [2:0]  m_axi_arprot, m_axi_awprot;
    logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready;
    logic [1:0]  m_axi_rresp, m_axi_bresp;
    logic [3:0]  m_axi_wstrb;

    always #5 clk = ~clk;

    mem_axi_bridge dut (
        .clk(clk), .rstn(rstn),
        .request_enable(request_enable), .mode(mode), .addr(addr),
        .wdata(wdata), .wstrb(wstrb),
        .response_enable(response_enable), .data(data),
        .resp_error(resp_error), .busy(busy), .req_overrun(req_overrun),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    int n_cmp = 0;
    int n_mis = 0;
    bit exp_ovr = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_idle();
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00;  m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b0;  m_axi_bresp = 2'b00;
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_valids"}, 32'({m_axi_arvalid, m_axi_rready,
                  m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_resp_en"}, 32'(response_enable), 32'd0);
    endtask

    // One full transaction. The slave waits *_dly cycles before ready/valid.
    // ovr_cyc: cycle (0 = first cycle after acceptance) in which a stray
    // request is injected; ovr_resp: inject a stray request in the response cycle.
    task automatic run_txn(input logic md, input logic [31:0] a, wd,
                           input logic [3:0] ws, input int ar_dly, aw_dly,
                           w_dly, r_dly, b_dly, input logic [1:0] rsp,
                           input logic [31:0] rd, input int ovr_cyc,
                           input bit ovr_resp);
        int cyc = 0, ar_cnt = 0, aw_cnt = 0, w_cnt = 0, rb_cnt = 0;
        int ar_n = 0, aw_n = 0, w_n = 0, exp_lat;
        bit ar_done = 0, aw_done = 0, w_done = 0, rb_done = 0, got = 0;
        bit p_arv = 0, p_awv = 0, p_wv = 0, p_ar_hs = 0, p_aw_hs = 0, p_w_hs = 0;
        bit ar_hs, aw_hs, w_hs, rb_hs, phase;
        logic [31:0] exp_data = (md == MEMREQ_READ) ? rd : 32'd0;
        exp_lat = (md == MEMREQ_READ) ? ar_dly + r_dly + 2
                : ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly + 2;

        request_enable = 1'b1; mode = md; addr = a; wdata = wd; wstrb = ws;
        step();
        while (!got && cyc < 200) begin
            // Request-side inputs wander; outputs must hold the latched values.
            addr = $urandom & 32'hFFFF_FFFC; wdata = $urandom;
            wstrb = 4'($urandom); mode = 1'($urandom);
            request_enable = (cyc == ovr_cyc) || (response_enable && ovr_resp);
            if (request_enable) exp_ovr = 1'b1;
            if (response_enable) begin
                got = 1'b1;
                slave_idle();
                check_val("resp_data", data, exp_data);
                check_val("resp_error", 32'(resp_error), 32'(rsp != 2'b00));
                check_val("resp_busy", 32'(busy), 32'd0);
                check_val("latency", 32'(cyc), 32'(exp_lat));
            end else begin
                check_val("err_low", 32'(resp_error), 32'd0);
                check_val("busy", 32'(busy), 32'd1);
                if (p_arv && !p_ar_hs) check_val("arvalid_hold", 32'(m_axi_arvalid), 32'd1);
                if (p_awv && !p_aw_hs) check_val("awvalid_hold", 32'(m_axi_awvalid), 32'd1);
                if (p_wv && !p_w_hs)   check_val("wvalid_hold", 32'(m_axi_wvalid), 32'd1);
                if (m_axi_arvalid) check_val("araddr", m_axi_araddr, a);
                if (m_axi_awvalid) check_val("awaddr", m_axi_awaddr, a);
                if (m_axi_wvalid) begin
                    check_val("wdata", m_axi_wdata, wd);
                    check_val("wstrb", 32'(m_axi_wstrb), 32'(ws));
                end
                if (m_axi_bready) check_val("bready_early", 32'(aw_done && w_done), 32'd1);
                if (md == MEMREQ_READ)
                    check_val("rd_no_wr", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'd0);
                else
                    check_val("wr_no_rd", 32'({m_axi_arvalid, m_axi_rready}), 32'd0);

                phase = (md == MEMREQ_READ) ? ar_done : (aw_done && w_done);
                m_axi_arready = (ar_cnt >= ar_dly);
                m_axi_awready = (aw_cnt >= aw_dly);
                m_axi_wready  = (w_cnt >= w_dly);
                m_axi_rvalid  = (md == MEMREQ_READ) && phase && !rb_done && rb_cnt >= r_dly;
                m_axi_bvalid  = (md == MEMREQ_WRITE) && phase && !rb_done && rb_cnt >= b_dly;
                m_axi_rdata   = m_axi_rvalid ? rd : $urandom;
                m_axi_rresp   = m_axi_rvalid ? rsp : 2'($urandom);
                m_axi_bresp   = m_axi_bvalid ? rsp : 2'($urandom);

                ar_hs = m_axi_arvalid && m_axi_arready;
                aw_hs = m_axi_awvalid && m_axi_awready;
                w_hs  = m_axi_wvalid && m_axi_wready;
                rb_hs = (m_axi_rvalid && m_axi_rready) || (m_axi_bvalid && m_axi_bready);
                if (m_axi_arvalid) ar_cnt++;
                if (m_axi_awvalid) aw_cnt++;
                if (m_axi_wvalid)  w_cnt++;
                if (phase) rb_cnt++;
                if (ar_hs) begin ar_n++; ar_done = 1'b1; end
                if (aw_hs) begin aw_n++; aw_done = 1'b1; end
                if (w_hs)  begin w_n++;  w_done  = 1'b1; end
                if (rb_hs) rb_done = 1'b1;
                p_arv = m_axi_arvalid; p_awv = m_axi_awvalid; p_wv = m_axi_wvalid;
                p_ar_hs = ar_hs; p_aw_hs = aw_hs; p_w_hs = w_hs;
                step();
                cyc++;
            end
        end
        check_val("resp_seen", 32'(got), 32'd1);
        check_val("ar_count", 32'(ar_n), 32'(md == MEMREQ_READ));
        check_val("aw_count", 32'(aw_n), 32'(md == MEMREQ_WRITE));
        check_val("w_count", 32'(w_n), 32'(md == MEMREQ_WRITE));
        step();
        request_enable = 1'b0;
        check_quiet("after_resp");
        check_val("err_after", 32'(resp_error), 32'd0);
        check_val("overrun", 32'(req_overrun), 32'(exp_ovr));
    endtask

    initial begin
        rstn = 1'b0; request_enable = 1'b0; mode = 1'b0;
        addr = '0; wdata = '0; wstrb = '0;
        slave_idle();
        step(); step();
        check_quiet("reset");
        check_val("reset_data", data, 32'd0);
        check_val("reset_araddr", m_axi_araddr, 32'd0);
        check_val("reset_awaddr", m_axi_awaddr, 32'd0);
        check_val("reset_wdata", m_axi_wdata, 32'd0);
        check_val("reset_ovr", 32'(req_overrun), 32'd0);
        rstn = 1'b1;
        step();

        // zero-wait read
        run_txn(MEMREQ_READ, 32'h8000_1000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, -1, 0);
        // zero-wait write
        run_txn(MEMREQ_WRITE, 32'h0000_0200, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, -1, 0);
        // write, W accepted before AW
        run_txn(MEMREQ_WRITE, 32'h0000_0100, 32'h00AB_0000, 4'b0100, 0, 3, 0, 0, 1, 2'b00, 0, -1, 0);
        // AW before W
        run_txn(MEMREQ_WRITE, 32'h0000_0104, 32'hCAFE_0000, 4'b1100, 0, 0, 4, 0, 0, 2'b00, 0, -1, 0);
        // error responses, then an OKAY read
        run_txn(MEMREQ_READ, 32'h0000_0300, 0, 0, 0, 0, 0, 1, 0, 2'b10, 32'h5555_AAAA, -1, 0);
        run_txn(MEMREQ_WRITE, 32'h0000_0304, 32'h0F0F_0F0F, 4'b0011, 0, 1, 1, 0, 2, 2'b11, 0, -1, 0);
        run_txn(MEMREQ_READ, 32'h0000_0308, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0BAD_F00D, -1, 0);
        // AR back-pressure for 5 cycles
        run_txn(MEMREQ_READ, 32'h4000_0040, 0, 0, 5, 0, 0, 0, 0, 2'b00, 32'h7777_1111, -1, 0);
        // overrun during RD_DATA; the next request follows right after the response
        run_txn(MEMREQ_READ, 32'h0000_0400, 0, 0, 0, 0, 0, 3, 0, 2'b00, 32'hA5A5_5A5A, 2, 0);
        run_txn(MEMREQ_READ, 32'h0000_0404, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h1357_9BDF, -1, 1);
        run_txn(MEMREQ_WRITE, 32'h0000_0408, 32'h2468_ACE0, 4'b1001, 1, 0, 0, 0, 0, 2'b00, 0, -1, 0);

        // reset in the middle of a write
        request_enable = 1'b1; mode = MEMREQ_WRITE; addr = 32'h0000_0500;
        wdata = 32'hFFFF_0000; wstrb = 4'hF;
        step();
        request_enable = 1'b0;
        step();
        check_val("midwr_awvalid", 32'(m_axi_awvalid), 32'd1);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        exp_ovr = 1'b0;
        check_quiet("midwr_reset");
        check_val("midwr_ovr", 32'(req_overrun), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_quiet("midwr_after");
        end
        run_txn(MEMREQ_READ, 32'h0000_0600, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'hFACE_B00C, -1, 0);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            logic       md;
            logic [1:0] rsp;
            int         gap;
            md  = 1'($urandom);
            rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(md, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), rsp, $urandom,
                    ($urandom_range(0, 7) == 0) ? 0 : -1, ($urandom_range(0, 7) == 0));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
